alu_op_queue: RTL and testbench

ALU_OP_QUEUE -- requirements
Module: alu_op_queue

---
 rtl/alu_op_queue.sv | 127 ++++++++++++
 tb/tb_alu_op_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_queue.sv
// alu_op_queue: 4-entry decode-and-hold FIFO feeding the 32-bit ALU with {op, a, b}.
// Latency: an entry pushed at edge N is presented on out_* from edge N; no same-cycle bypass.
// Backpressure: in_ready = (count != 4) from registered state only; out_* hold while !out_ready.
// Optional feature: `define ALU_QUEUE_ILLEGAL_TRAP_EN to drop illegal functs and raise sticky err;
// otherwise illegal functs are enqueued as ADD and err stays 0.
module alu_op_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  count,
    output logic        err,
    input  logic        err_clr
);

    localparam int DEPTH = 4;

    logic [2:0]  r_op [DEPTH];
    logic [31:0] r_a  [DEPTH];
    logic [31:0] r_b  [DEPTH];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic        w_push_hs;
    logic        w_push;
    logic        w_pop;
    logic        w_legal;
    logic [2:0]  w_dec;
    logic [2:0]  w_op;

    assign in_ready  = (r_count != 3'd4);
    assign out_valid = (r_count != 3'd0);
    assign count     = r_count;
    assign out_op    = r_op[r_rd_ptr];
    assign out_a     = r_a[r_rd_ptr];
    assign out_b     = r_b[r_rd_ptr];

    assign w_push_hs = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Decode the R-type funct field into the 3-bit ALU opcode
    always_comb begin
        w_legal = 1'b1;
        w_dec   = 3'b010;
        case (in_funct)
            6'h24:   w_dec = 3'b000;
            6'h25:   w_dec = 3'b001;
            6'h20:   w_dec = 3'b010;
            6'h26:   w_dec = 3'b011;
            6'h22:   w_dec = 3'b100;
            6'h02:   w_dec = 3'b101;
            6'h00:   w_dec = 3'b110;
            6'h27:   w_dec = 3'b111;
            default: w_legal = 1'b0;
        endcase
    end

`ifdef ALU_QUEUE_ILLEGAL_TRAP_EN
    logic r_err;

    // Illegal functs still complete the handshake but are dropped
    assign w_push = w_push_hs && w_legal;
    assign w_op   = w_dec;
    assign err    = r_err;

    // Sticky error: an illegal push in the same cycle beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_push_hs && !w_legal) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end
`else
    logic w_unused_err_clr;

    // Illegal functs are enqueued as ADD; the error path does not exist here
    assign w_push           = w_push_hs;
    assign w_op             = w_legal ? w_dec : 3'b010;
    assign err              = 1'b0;
    assign w_unused_err_clr = err_clr;
`endif

    // Entry storage; cleared on reset so the head reads as zero while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i] <= 3'b000;
                r_a[i]  <= 32'd0;
                r_b[i]  <= 32'd0;
            end
        end else if (w_push) begin
            r_op[r_wr_ptr] <= w_op;
            r_a[r_wr_ptr]  <= in_a;
            r_b[r_wr_ptr]  <= in_b;
        end
    end

    // Pointers wrap naturally at 2 bits; count tracks push minus pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

endmodule

// File: tb/tb_alu_op_queue.sv
// Bench for alu_op_queue: directed scenarios with literal expectations plus a randomized
// run, all checked against a queue-based reference model on every falling clock edge.
module tb_alu_op_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_funct = 6'd0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  count;
    logic        err;
    logic        err_clr = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    alu_op_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct  (in_funct),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b),
        .count     (count),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t mq[$];
    logic m_err = 1'b0;
    logic [5:0] legal_f [8] = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h22, 6'h02, 6'h00, 6'h27};

    // opcode = position of the funct in the legal list; -1 when illegal
    function automatic int lookup(input logic [5:0] f);
        for (int i = 0; i < 8; i++) begin
            if (legal_f[i] == f) return i;
        end
        return -1;
    endfunction

    bit   mdl_push;
    bit   mdl_pop;
    int   mdl_idx;
    ent_t mdl_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            mdl_idx  = lookup(in_funct);
            mdl_push = in_valid && (mq.size() != 4);
            mdl_pop  = out_ready && (mq.size() != 0);
`ifdef ALU_QUEUE_ILLEGAL_TRAP_EN
            if (mdl_push && mdl_idx < 0) m_err = 1'b1;
            else if (err_clr)            m_err = 1'b0;
            if (mdl_idx < 0) mdl_push = 1'b0;
`endif
            if (mdl_pop) void'(mq.pop_front());
            if (mdl_push) begin
                mdl_e.op = (mdl_idx < 0) ? 3'd2 : 3'(mdl_idx);
                mdl_e.a  = in_a;
                mdl_e.b  = in_b;
                mq.push_back(mdl_e);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every observable output against the model away from the active edge
    always @(negedge clk) begin
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() != 4));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("err", 32'(err), 32'(m_err));
        if (mq.size() != 0) begin
            chk("out_op", 32'(out_op), 32'(mq[0].op));
            chk("out_a", out_a, mq[0].a);
            chk("out_b", out_b, mq[0].b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b0;
    endtask

    logic [5:0] fill_f [4] = '{6'h24, 6'h25, 6'h26, 6'h22};
    logic [2:0] exp_ops [4] = '{3'b000, 3'b001, 3'b011, 3'b100};

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        #10 rst_n = 1'b1;

        // First push into empty queue
        in_valid = 1'b1; in_funct = 6'h20; in_a = 32'd5; in_b = 32'd7;
        step();
        in_valid = 1'b0;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_op", 32'(out_op), 32'b010);
        chk("first_a", out_a, 32'd5);
        chk("first_b", out_b, 32'd7);
        chk("first_count", 32'(count), 32'd1);
        drain();

        // Fill to four, then a refused fifth push
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_funct = fill_f[i]; in_a = 32'(i + 100); in_b = 32'(i + 200);
            step();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_funct = 6'h20; in_a = 32'hDEAD;
        step();
        in_valid = 1'b0;
        chk("fifth_refused", 32'(count), 32'd4);

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_op", 32'(out_op), 32'(exp_ops[i]));
            chk("drain_a", out_a, 32'(i + 100));
            step();
        end
        out_ready = 1'b0;
        chk("drained_count", 32'(count), 32'd0);

        // Full queue with push and pop offered together
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_funct = 6'h02; in_a = 32'(i); in_b = 32'(i);
            step();
        end
        in_funct = 6'h27; in_a = 32'h1234; in_b = 32'h5678; out_ready = 1'b1;
        step();
        chk("full_pushpop_count", 32'(count), 32'd3);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("full_next_push", 32'(count), 32'd4);
        drain();

        // Steady push+pop from count 2
        in_valid = 1'b1; in_funct = 6'h00;
        for (int i = 0; i < 2; i++) begin
            in_a = $urandom; in_b = $urandom;
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_funct = legal_f[$urandom_range(0, 7)]; in_a = $urandom; in_b = $urandom;
            step();
            chk("steady_count", 32'(count), 32'd2);
        end
        drain();

        // Illegal funct
        in_valid = 1'b1; in_funct = 6'h3F; in_a = 32'd9; in_b = 32'd11;
        step();
        in_valid = 1'b0;
`ifdef ALU_QUEUE_ILLEGAL_TRAP_EN
        chk("trap_count", 32'(count), 32'd0);
        chk("trap_err", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("trap_err_clr", 32'(err), 32'd0);
        in_valid = 1'b1; err_clr = 1'b1;
        step();
        in_valid = 1'b0; err_clr = 1'b0;
        chk("trap_set_wins", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
`else
        chk("illegal_op", 32'(out_op), 32'b010);
        chk("illegal_a", out_a, 32'd9);
        chk("illegal_b", out_b, 32'd11);
        chk("illegal_err", 32'(err), 32'd0);
        drain();
`endif

        // Reset mid-cycle with three entries queued
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_funct = 6'h26; in_a = 32'(i + 7); in_b = 32'(i);
            step();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_a", out_a, 32'd0);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; in_funct = 6'h25; in_a = 32'hAAAA; in_b = 32'h5555;
        step();
        in_valid = 1'b0;
        chk("postrst_op", 32'(out_op), 32'b001);
        chk("postrst_a", out_a, 32'hAAAA);
        chk("postrst_b", out_b, 32'h5555);
        chk("postrst_count", 32'(count), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 7) == 0);
            in_funct  = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 7)] : 6'($urandom);
            in_a      = $urandom;
            in_b      = $urandom;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        step();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
